// File: rtl/stream_window.sv
// stream_window: region-of-interest cropper for the imager pixel stream.
// Forwards frame framing and header/metadata beats, and drops row markers and
// pixels outside a window that is latched at every FRAME_START.

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 8
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 8'h01
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 8'h02
`endif
`ifndef DTYPE_ROW_START
`define DTYPE_ROW_START 8'h03
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 8'h04
`endif
`ifndef DTYPE_PIXEL_MASK
`define DTYPE_PIXEL_MASK 8'hF0
`endif

module stream_window #(
  parameter int unsigned PIXEL_WIDTH       = 10,
  parameter int unsigned STREAM_DATA_WIDTH = 16,
  parameter int unsigned DIM_WIDTH         = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [DIM_WIDTH-1:0]         win_col_start,
  input  logic [DIM_WIDTH-1:0]         win_num_cols,
  input  logic [DIM_WIDTH-1:0]         win_row_start,
  input  logic [DIM_WIDTH-1:0]         win_num_rows,
  input  logic                         dvi,
  input  logic [`DTYPE_WIDTH-1:0]      dtypei,
  input  logic [PIXEL_WIDTH-1:0]       datai,
  input  logic [STREAM_DATA_WIDTH-1:0] meta_datai,
  output logic                         dvo,
  output logic [`DTYPE_WIDTH-1:0]      dtypeo,
  output logic [PIXEL_WIDTH-1:0]       datao,
  output logic [STREAM_DATA_WIDTH-1:0] meta_datao,
  output logic                         busy
);

  localparam int unsigned SUM_W = DIM_WIDTH + 1;
  localparam int unsigned DT_W  = `DTYPE_WIDTH;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t                       state_q, state_d;
  logic                         en_q, en_d;
  logic [DIM_WIDTH-1:0]         col_start_q, col_start_d;
  logic [DIM_WIDTH-1:0]         num_cols_q, num_cols_d;
  logic [DIM_WIDTH-1:0]         row_start_q, row_start_d;
  logic [DIM_WIDTH-1:0]         num_rows_q, num_rows_d;
  logic [DIM_WIDTH-1:0]         row_q, row_d;
  logic [DIM_WIDTH-1:0]         col_q, col_d;
  logic                         dvo_q, dvo_d;
  logic [DT_W-1:0]              dtypeo_q, dtypeo_d;
  logic [PIXEL_WIDTH-1:0]       datao_q, datao_d;
  logic [STREAM_DATA_WIDTH-1:0] meta_datao_q, meta_datao_d;
  logic                         busy_q, busy_d;

  logic is_fs_c, is_fe_c, is_rs_c, is_re_c, is_pix_c;
  logic row_in_c, col_in_c, fwd_c;
  logic [SUM_W-1:0] row_end_c, col_end_c;

  // Beat classification and window membership against the latched window
  always_comb begin
    is_fs_c   = (dtypei == DT_W'(`DTYPE_FRAME_START));
    is_fe_c   = (dtypei == DT_W'(`DTYPE_FRAME_END));
    is_rs_c   = (dtypei == DT_W'(`DTYPE_ROW_START));
    is_re_c   = (dtypei == DT_W'(`DTYPE_ROW_END));
    is_pix_c  = |(dtypei & DT_W'(`DTYPE_PIXEL_MASK));
    row_end_c = SUM_W'(row_start_q) + SUM_W'(num_rows_q);
    col_end_c = SUM_W'(col_start_q) + SUM_W'(num_cols_q);
    row_in_c  = (row_q >= row_start_q) && (SUM_W'(row_q) < row_end_c);
    col_in_c  = (col_q >= col_start_q) && (SUM_W'(col_q) < col_end_c);
  end

  // State, latched window, counters and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      en_q         <= 1'b0;
      col_start_q  <= '0;
      num_cols_q   <= '0;
      row_start_q  <= '0;
      num_rows_q   <= '0;
      row_q        <= '0;
      col_q        <= '0;
      dvo_q        <= 1'b0;
      dtypeo_q     <= '0;
      datao_q      <= '0;
      meta_datao_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      en_q         <= en_d;
      col_start_q  <= col_start_d;
      num_cols_q   <= num_cols_d;
      row_start_q  <= row_start_d;
      num_rows_q   <= num_rows_d;
      row_q        <= row_d;
      col_q        <= col_d;
      dvo_q        <= dvo_d;
      dtypeo_q     <= dtypeo_d;
      datao_q      <= datao_d;
      meta_datao_q <= meta_datao_d;
      busy_q       <= busy_d;
    end
  end

  // Next state: frame tracking, window latch and saturating row/col counters
  always_comb begin
    state_d     = state_q;
    en_d        = en_q;
    col_start_d = col_start_q;
    num_cols_d  = num_cols_q;
    row_start_d = row_start_q;
    num_rows_d  = num_rows_q;
    row_d       = row_q;
    col_d       = col_q;
    if (dvi) begin
      if (is_fs_c) begin
        state_d     = ACTIVE;
        en_d        = enable;
        col_start_d = win_col_start;
        num_cols_d  = win_num_cols;
        row_start_d = win_row_start;
        num_rows_d  = win_num_rows;
        row_d       = '0;
        col_d       = '0;
      end else if (state_q == ACTIVE) begin
        if (is_fe_c) begin
          state_d = IDLE;
        end else if (is_rs_c) begin
          col_d = '0;
        end else if (is_re_c) begin
          row_d = (&row_q) ? row_q : row_q + DIM_WIDTH'(1);
        end else if (is_pix_c) begin
          col_d = (&col_q) ? col_q : col_q + DIM_WIDTH'(1);
        end
      end
    end
  end

  // Output: forward decision; dropped beats hold the previous payload
  always_comb begin
    fwd_c        = 1'b0;
    dvo_d        = 1'b0;
    dtypeo_d     = dtypeo_q;
    datao_d      = datao_q;
    meta_datao_d = meta_datao_q;
    busy_d       = (state_d == ACTIVE);
    if (dvi) begin
      if (is_fs_c) begin
        fwd_c = 1'b1;
      end else if (state_q == ACTIVE) begin
        if (!en_q || is_fe_c) begin
          fwd_c = 1'b1;
        end else if (is_rs_c || is_re_c) begin
          fwd_c = row_in_c && (num_cols_q != '0);
        end else if (is_pix_c) begin
          fwd_c = row_in_c && col_in_c;
        end else begin
          fwd_c = 1'b1;
        end
      end
    end
    if (fwd_c) begin
      dvo_d        = 1'b1;
      dtypeo_d     = dtypei;
      datao_d      = datai;
      meta_datao_d = meta_datai;
    end
  end

  assign dvo        = dvo_q;
  assign dtypeo     = dtypeo_q;
  assign datao      = datao_q;
  assign meta_datao = meta_datao_q;
  assign busy       = busy_q;

endmodule
